// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory requester and its memory model.
// State encoding, memory window constants and access direction codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int unsigned DMEM_BASE  = 4096;
  localparam int unsigned DMEM_DEPTH = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // 33-bit bound so base+depth can never wrap
  function automatic logic in_range(
    input logic [31:0] a,
    input int unsigned base,
    input int unsigned depth
  );
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + {1'b0, depth};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

endpackage

// File: rtl/dmem_requester_if.sv
// Requester-to-data-memory strobe/ready bus.
// master = requester side, slave = memory side.
interface dmem_requester_if;
  import dmem_pkg::*;

  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_ready;

  modport master (
    output mem_valid,
    output mem_rw,
    output mem_addr,
    output mem_wr_data,
    input  mem_rd_data,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_rw,
    input  mem_addr,
    input  mem_wr_data,
    output mem_rd_data,
    output mem_ready
  );

endinterface

// File: rtl/dmem_requester.sv
// MEM-stage initiator: one load/store at a time to the data memory,
// with range check, ready timeout and saturating error counter.
module dmem_requester
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BASE  = DMEM_BASE,
  parameter int unsigned ADDR_DEPTH = DMEM_DEPTH,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_rw,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wr_data,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [31:0] o_resp_rd_data,
  output logic [7:0]  o_err_count,
  dmem_requester_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_tcnt;
  logic [CW-1:0] w_tcnt_d;
  logic [CW-1:0] w_tcnt_inc;
  logic          w_in_range;
  logic          w_issue;
  logic          w_ok;
  logic          w_err_go;
  logic          w_is_load;

  logic          r_mem_valid;
  logic          r_mem_rw;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wr_data;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [31:0]   r_resp_rd_data;
  logic [7:0]    r_err_cnt;

  assign w_in_range = in_range(i_req_addr, ADDR_BASE, ADDR_DEPTH);
  assign w_tcnt_inc = r_tcnt + CW'(1);
  assign w_is_load  = (r_mem_rw != RW_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_tcnt_d = r_tcnt;
    w_issue  = 1'b0;
    w_ok     = 1'b0;
    w_err_go = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_in_range) begin
            w_next  = S_ISSUE;
            w_issue = 1'b1;
          end else begin
            w_next   = S_RESP;
            w_err_go = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        w_next   = S_WAIT;
        w_tcnt_d = '0;
      end
      S_WAIT: begin
        if (mem.mem_ready) begin
          w_next = S_RESP;
          w_ok   = 1'b1;
        end else begin
          w_tcnt_d = w_tcnt_inc;
          if (w_tcnt_inc == CW'(TIMEOUT)) begin
            w_next   = S_RESP;
            w_err_go = 1'b1;
          end
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid    <= 1'b0;
      r_mem_rw       <= RW_READ;
      r_mem_addr     <= '0;
      r_mem_wr_data  <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_err     <= 1'b0;
      r_resp_rd_data <= '0;
      r_err_cnt      <= '0;
      r_tcnt         <= '0;
    end else begin
      r_mem_valid  <= w_issue;
      r_resp_valid <= w_ok | w_err_go;
      r_resp_err   <= w_err_go;
      r_tcnt       <= w_tcnt_d;
      if (w_issue) begin
        r_mem_rw      <= i_req_rw;
        r_mem_addr    <= i_req_addr;
        r_mem_wr_data <= i_req_wr_data;
      end
      if (w_ok && w_is_load)
        r_resp_rd_data <= mem.mem_rd_data;
      if (w_err_go && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_stall = (r_state == S_IDLE && i_req_valid)
                 || r_state == S_ISSUE
                 || r_state == S_WAIT;

  assign o_resp_valid   = r_resp_valid;
  assign o_resp_err     = r_resp_err;
  assign o_resp_rd_data = r_resp_rd_data;
  assign o_err_count    = r_err_cnt;

  assign mem.mem_valid   = r_mem_valid;
  assign mem.mem_rw      = r_mem_rw;
  assign mem.mem_addr    = r_mem_addr;
  assign mem.mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_dmem_requester.sv
// Bench for dmem_requester: memory model with programmable ready delay
// and a transaction-level reference for latency, data and error count.
module tb_dmem_requester;
  import dmem_pkg::*;

  localparam int TO = 8;

  typedef logic [31:0] mem_t [16];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < 16; i++) m[i] = 32'hC0DE_0000 + 32'(i * 17);
    return m;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wr_data = '0;
  logic        stall;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rd_data;
  logic [7:0]  err_count;

  dmem_requester_if mif ();

  dmem_requester dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .i_req_rw       (req_rw),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_wr_data),
    .o_stall        (stall),
    .o_resp_valid   (resp_valid),
    .o_resp_err     (resp_err),
    .o_resp_rd_data (resp_rd_data),
    .o_err_count    (err_count),
    .mem            (mif)
  );

  always #5 clk = ~clk;

  // memory model: acts on the strobe, raises ready 'delay' cycles later
  mem_t mem = init_mem();
  int   delay = 0;
  int   cnt = 0;
  bit   pend = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mif.mem_ready   <= 1'b0;
      mif.mem_rd_data <= '0;
      pend            <= 1'b0;
      cnt             <= 0;
    end else begin
      mif.mem_ready <= 1'b0;
      if (mif.mem_valid) begin
        if (mif.mem_rw == RW_WRITE)
          mem[mif.mem_addr[3:0]] <= mif.mem_wr_data;
        mif.mem_rd_data <= mem[mif.mem_addr[3:0]];
        pend <= (delay != 0);
        cnt  <= delay;
        if (delay == 0) mif.mem_ready <= 1'b1;
      end else if (pend) begin
        if (cnt == 1) begin
          mif.mem_ready <= 1'b1;
          pend          <= 1'b0;
        end
        cnt <= cnt - 1;
      end
    end
  end

  int          tests = 0;
  int          fails = 0;
  mem_t        refmem = init_mem();
  int          exp_err = 0;
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_maddr = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic rw, input logic [31:0] addr,
                        input logic [31:0] data, input int d);
    bit inr;
    bit err_e;
    int exp_lat;
    int lat;
    int strobes;
    int stalls;
    inr = (addr >= DMEM_BASE) && (addr < DMEM_BASE + DMEM_DEPTH);
    if (!inr) begin
      exp_lat = 1;
      err_e   = 1'b1;
    end else if (d < TO) begin
      exp_lat = 3 + d;
      err_e   = 1'b0;
    end else begin
      exp_lat = 2 + TO;
      err_e   = 1'b1;
    end
    if (inr) begin
      exp_maddr = addr;
      if (rw == RW_WRITE) refmem[(addr - DMEM_BASE) & 15] = data;
      else if (!err_e) exp_rd = refmem[(addr - DMEM_BASE) & 15];
    end
    if (err_e && exp_err < 255) exp_err++;

    delay = d;
    @(negedge clk);
    req_valid   = 1'b1;
    req_rw      = rw;
    req_addr    = addr;
    req_wr_data = data;
    #1;
    stalls  = int'(stall);
    strobes = 0;
    lat     = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (mif.mem_valid) begin
        strobes++;
        chk("mem_addr", mif.mem_addr, addr);
        chk("mem_rw", 32'(mif.mem_rw), 32'(rw));
        if (rw == RW_WRITE) chk("mem_wr_data", mif.mem_wr_data, data);
      end
      if (resp_valid) break;
      stalls += int'(stall);
    end
    chk("latency", lat, exp_lat);
    chk("resp_err", 32'(resp_err), 32'(err_e));
    chk("stall_in_resp", 32'(stall), 0);
    chk("stall_cycles", stalls, exp_lat);
    chk("strobes", strobes, 32'(inr));
    chk("resp_rd_data", resp_rd_data, exp_rd);
    chk("err_count", 32'(err_count), exp_err);
    chk("mem_addr_hold", mif.mem_addr, exp_maddr);
    @(posedge clk);
    #1;
    chk("resp_valid_drop", 32'(resp_valid), 0);
    chk("resp_err_drop", 32'(resp_err), 0);
    chk("no_dup_strobe", 32'(mif.mem_valid), 0);
  endtask

  task automatic reset_at(input logic [31:0] addr, input int k);
    delay = 1000;
    @(negedge clk);
    req_valid   = 1'b1;
    req_rw      = RW_READ;
    req_addr    = addr;
    req_wr_data = '0;
    repeat (k) @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_mem_valid", 32'(mif.mem_valid), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_rd_data", resp_rd_data, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    exp_err   = 0;
    exp_rd    = '0;
    exp_maddr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_valid", 32'(mif.mem_valid), 0);
    chk("reset_mem_rw", 32'(mif.mem_rw), 0);
    chk("reset_mem_addr", mif.mem_addr, 0);
    chk("reset_mem_wr_data", mif.mem_wr_data, 0);
    chk("reset_resp_valid", 32'(resp_valid), 0);
    chk("reset_resp_err", 32'(resp_err), 0);
    chk("reset_rd_data", resp_rd_data, 0);
    chk("reset_err_count", 32'(err_count), 0);
    chk("reset_stall", 32'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_txn(RW_WRITE, 32'd4100, 32'hDEAD_BEEF, 0);
    do_txn(RW_READ,  32'd4100, 32'h0, 0);
    chk("load_deadbeef", resp_rd_data, 32'hDEAD_BEEF);

    do_txn(RW_READ,  32'd4095, 32'h0, 0);
    do_txn(RW_WRITE, 32'd4112, 32'h1234_5678, 0);
    chk("err_count_two", 32'(err_count), 2);
    do_txn(RW_READ,  32'd4111, 32'h0, 2);

    do_txn(RW_READ,  32'd4101, 32'h0, 1000);

    do_txn(RW_READ, 32'd4096, 32'h0, 0);
    do_txn(RW_READ, 32'd4097, 32'h0, 0);
    do_txn(RW_READ, 32'd4098, 32'h0, 0);

    reset_at(32'd4102, 1);
    reset_at(32'd4103, 4);
    reset_at(32'd5000, 1);
    do_txn(RW_READ, 32'd4099, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom_range(0, 1)), 32'($urandom_range(4088, 4119)),
             $urandom, $urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        #1;
        chk("idle_stall", 32'(stall), 0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end

    for (int i = 0; i < 256; i++) begin
      if (i[0]) do_txn(RW_READ, 32'($urandom_range(0, 4095)), 32'h0, 0);
      else      do_txn(RW_WRITE, 32'($urandom_range(4112, 9000)), $urandom, 0);
    end
    chk("err_saturated", 32'(err_count), 255);

    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_requester.md
Name: dmem_requester

Overview:
- Processor-side initiator for the single-ported data memory. It accepts one load/store from the pipeline and stalls the pipeline while busy.
- It issues a one-cycle valid/rw/addr/wr_data strobe to the memory and waits for the memory's ready. It then returns read data or an error to the pipeline for one cycle.
- It sits between the pipeline's MEM stage and the data memory.

Parameters:
- ADDR_BASE, 4096, first legal word address of data memory.
- ADDR_DEPTH, 16, number of words; legal range is ADDR_BASE to ADDR_BASE+ADDR_DEPTH-1.
- TIMEOUT, 8, maximum WAIT cycles without mem_ready before aborting with error; must be at least 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline requests an access; held stable with req_* while stall=1.
- req_rw  in  1  1=store, 0=load.
- req_addr  in  32  word address.
- req_wr_data  in  32  store data.
- stall  out  1  pipeline must hold; combinational from state and req_valid.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; 1 = out-of-range or timeout.
- resp_rd_data  out  32  load result, valid with resp_valid on a successful load.
- err_count  out  8  saturating count of error completions.
- mem_valid  out  1  memory strobe, exactly one cycle per access.
- mem_rw  out  1  to memory rw.
- mem_addr  out  32  to memory addr.
- mem_wr_data  out  32  to memory wr_data.
- mem_rd_data  in  32  from memory rd_data.
- mem_ready  in  1  from memory ready.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: mem_valid=0, mem_rw=0, mem_addr=0, mem_wr_data=0, resp_valid=0, resp_err=0, resp_rd_data=0, err_count=0, timeout counter=0.
- IDLE with req_valid=1 and address in range:
  - Latch rw, addr and wr_data into the mem_* registers.
  - Go to ISSUE; mem_valid=1 for that cycle only.
- IDLE with req_valid=1 and address out of range:
  - Go directly to RESP with resp_err=1.
  - No mem_valid is issued; mem_* registers are unchanged.
- ISSUE: mem_ready is ignored, because memory ready cannot be visible yet. Go to WAIT, clear the timeout counter, and set mem_valid=0.
- WAIT, mem_ready=1:
  - On a load, capture mem_rd_data into resp_rd_data.
  - Set resp_err=0 and go to RESP.
- WAIT, mem_ready=0: increment the counter. When the counter reaches TIMEOUT, set resp_err=1, leave resp_rd_data unchanged, and go to RESP.
- RESP:
  - resp_valid=1 and stall=0; the pipeline consumes the result and advances.
  - Unconditionally go to IDLE. req_* sampled during RESP belong to the completed access and are not reissued.
- mem_ready is ignored in IDLE, ISSUE and RESP, so a stale ready is never accepted.
- stall = (IDLE & req_valid) | ISSUE | WAIT.
- Nominal latency (memory answers the cycle after its strobe):
  - request seen in cycle c0, ISSUE c1, WAIT c2, RESP c3;
  - 3 stall cycles, back-to-back throughput of 1 access per 4 cycles.
- Out-of-range latency: request in c0, RESP in c1; 1 stall cycle.
- resp_rd_data holds its last value across stores, errors and idle cycles.
- err_count increments on entry to RESP with resp_err=1 and saturates at 255.
- resp_valid and resp_err deassert on leaving RESP.
- Asynchronous reset mid-access, in any state: all outputs return to reset values immediately and the FSM goes to IDLE. The interrupted store may or may not have been written.
- Address arithmetic: compare as unsigned 32-bit. The upper bound is computed in 33 bits so that ADDR_BASE+ADDR_DEPTH cannot wrap.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, RESP);
  - DMEM_BASE=4096 and DMEM_DEPTH=16 constants, shared with the memory model;
  - RW_READ=0 and RW_WRITE=1.
- No sub-module: FSM, range check, timeout counter and error counter fit in one module.

Test Plan:
- Store, req_addr=4100, wr_data=0xDEADBEEF, then load 4100 -> mem_valid high exactly 1 cycle each; store gives resp_valid in c3 with resp_err=0; load gives resp_rd_data=0xDEADBEEF in its c3.
- Load req_addr=4095 and store req_addr=4112 -> RESP in c1 with resp_err=1, no mem_valid pulse, err_count=2.
- Memory model with ready tied 0 -> after ISSUE, 8 WAIT cycles, then resp_valid=1, resp_err=1; stall drops in RESP; resp_rd_data unchanged.
- Three back-to-back loads at 4096, 4097, 4098 with req_valid held -> mem_valid pulses every 4 cycles, three resp_valid pulses, correct data each, no duplicate strobes.
- Assert rst_n=0 during WAIT -> mem_valid, resp_valid and stall drop without waiting for clk; after release, next request at 4099 completes normally.
- Force 256 out-of-range requests -> err_count saturates at 255.
